// File: rtl/fifo_rd_stream.sv
// Read-side adapter: pulls words from an async FIFO read port (rd_en/empty, 1-cycle data) and
// re-presents them as a valid/ready stream via a 2-entry prefetch buffer. Optional macro: FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic [DW-1:0] fifo_rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    level
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [CW-1:0] xfer_count
`endif
);

  logic          run_q;
  logic [1:0]    occ_q, occ_d;
  logic          pend_q;
  logic          wptr_q;
  logic          rptr_q, rptr_d;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic [DW-1:0] buf_q [2];
  logic [DW-1:0] buf_d [2];
  logic          pop;
  logic [2:0]    fill_after;

  assign pop = out_valid_q & out_ready;

  // Words that will be buffered or in flight after this cycle; never allowed past 2.
  assign fill_after = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
  assign fifo_rd_en = run_q & ~fifo_empty & (fill_after < 3'd2);

  always_comb begin
    buf_d = buf_q;
    if (pend_q) begin
      buf_d[wptr_q] = fifo_rd_data;
    end
    rptr_d = rptr_q ^ pop;
    occ_d  = fill_after[1:0];
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          buf_q[gi] <= '0;
        end else begin
          buf_q[gi] <= buf_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      run_q       <= 1'b0;
      occ_q       <= 2'd0;
      pend_q      <= 1'b0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      run_q       <= 1'b1;
      occ_q       <= occ_d;
      pend_q      <= fifo_rd_en;
      wptr_q      <= wptr_q ^ pend_q;
      rptr_q      <= rptr_d;
      // Output registers look ahead at the next head so they line up with occ/rptr.
      out_valid_q <= (occ_d != 2'd0);
      out_data_q  <= buf_d[rptr_d];
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = occ_q;

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [CW-1:0] xfer_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      xfer_q <= '0;
    end else if (pop && (xfer_q != {CW{1'b1}})) begin
      xfer_q <= xfer_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign xfer_count = xfer_q;
`else
  localparam int unused_cw = CW;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO + word-count reference model, directed table and random traffic.
module tb_fifo_rd_stream;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    level;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [CW-1:0] xfer_count;
`endif

  always #5 clk = ~clk;

  fifo_rd_stream #(.DW(DW), .CW(CW)) dut (
    .clk          (clk),
    .nreset       (nreset),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .level        (level)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .xfer_count   (xfer_count)
`endif
  );

  int total = 0;
  int bad = 0;

  // Reference state: FIFO contents, words in stream order, and simple transfer counts.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  int            issued, popped, captured;
  bit            prev_rd, run_exp, have_rd;
  logic [DW-1:0] next_rd_data;
  int            cyc = 0;
  // DUT values seen in the latest step
  bit            s_rd, s_valid;
  logic [1:0]    s_level;
  logic [DW-1:0] s_data;

  typedef struct {
    bit          push;
    bit          rdy;
    bit          e_rd;
    bit          e_valid;
    logic [1:0]  e_level;
    logic [31:0] e_data;
  } vec_t;
  vec_t tv[5];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit gate, input bit rdy);
    int lvl;
    bit v_exp, pop_exp, rd_exp;
    @(negedge clk);
    cyc++;
    run_exp = 1'b1;
    if (have_rd) begin
      fifo_rd_data = next_rd_data;
      have_rd = 1'b0;
    end
    fifo_empty = gate || (fq.size() == 0);
    out_ready  = rdy;
    #1;
    s_rd = fifo_rd_en; s_valid = out_valid; s_level = level; s_data = out_data;
    lvl     = captured - popped;
    v_exp   = (lvl != 0);
    pop_exp = v_exp && rdy;
    rd_exp  = run_exp && !fifo_empty && ((issued - popped - int'(pop_exp)) < 2);
    chk("level", 32'(level), 32'(lvl));
    chk("out_valid", 32'(out_valid), 32'(v_exp));
    chk("rd_en", 32'(fifo_rd_en), 32'(rd_exp));
    if (v_exp) chk("out_data", out_data, exp_q[0]);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("xfer_count", 32'(xfer_count), 32'((popped > 15) ? 15 : popped));
`endif
    if (rd_exp) begin
      next_rd_data = fq.pop_front();
      have_rd = 1'b1;
      exp_q.push_back(next_rd_data);
      issued++;
    end
    if (pop_exp) begin
      void'(exp_q.pop_front());
      popped++;
    end
    captured += int'(prev_rd);
    prev_rd = rd_exp;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_data", out_data, 32'd0);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("rst_xfer", 32'(xfer_count), 32'd0);
`endif
    fq.delete(); exp_q.delete();
    issued = 0; popped = 0; captured = 0;
    prev_rd = 1'b0; have_rd = 1'b0; run_exp = 1'b0;
    repeat (2) @(negedge clk);
    fifo_empty = 1'b0;
    nreset = 1'b1;
    #1;
    chk("run_gate", 32'(fifo_rd_en), 32'd0);
    fifo_empty = 1'b1;
  endtask

  initial begin
    int first_pop, last_pop, npop, nrd, rpops, pushed, bound;

    tv[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0};
    tv[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0};
    tv[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'hA5A5_0001};
    tv[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'hA5A5_0001};
    tv[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0};

    do_reset();

    // First word latency
    for (int i = 0; i < 5; i++) begin
      if (tv[i].push) fq.push_back(32'hA5A5_0001);
      step(1'b0, tv[i].rdy);
      chk($sformatf("tv%0d_rd_en", i), 32'(s_rd), 32'(tv[i].e_rd));
      chk($sformatf("tv%0d_valid", i), 32'(s_valid), 32'(tv[i].e_valid));
      chk($sformatf("tv%0d_level", i), 32'(s_level), 32'(tv[i].e_level));
      if (tv[i].e_valid) chk($sformatf("tv%0d_data", i), s_data, tv[i].e_data);
    end

    // Streaming at full rate
    for (int i = 0; i < 16; i++) fq.push_back(32'(i));
    first_pop = -1; last_pop = -1; npop = 0;
    repeat (24) begin
      step(1'b0, 1'b1);
      if (s_valid) begin
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        npop++;
      end
    end
    chk("stream_pops", 32'(npop), 32'd16);
    chk("stream_span", 32'(last_pop - first_pop), 32'd15);

    // Backpressure
    for (int i = 0; i < 8; i++) fq.push_back(32'(100 + i));
    nrd = 0;
    repeat (10) begin
      step(1'b0, 1'b0);
      nrd += int'(s_rd);
    end
    chk("bp_rd_pulses", 32'(nrd), 32'd2);
    chk("bp_level", 32'(s_level), 32'd2);
    chk("bp_head", s_data, 32'd100);
    npop = 0;
    repeat (14) begin
      step(1'b0, 1'b1);
      npop += int'(s_valid);
    end
    chk("bp_pops", 32'(npop), 32'd8);
    chk("bp_level_end", 32'(s_level), 32'd0);

    // Reset with a full buffer
    for (int i = 0; i < 4; i++) fq.push_back(32'(200 + i));
    repeat (5) step(1'b0, 1'b0);
    chk("pre_rst_level", 32'(s_level), 32'd2);
    do_reset();

    // Random traffic
    rpops = 0; pushed = 0; bound = 0;
    while (rpops < 1000 && bound < 20000) begin
      bit rdy;
      if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
        fq.push_back($urandom);
        pushed++;
      end
      rdy = ($urandom_range(0, 1) == 1);
      step($urandom_range(0, 3) == 0, rdy);
      rpops += int'(s_valid && rdy);
      bound++;
    end
    chk("rand_pops", 32'(rpops), 32'd1000);

`ifdef FIFO_RD_STREAM_STATS_EN
    do_reset();
    for (int i = 0; i < 20; i++) fq.push_back(32'(300 + i));
    repeat (26) step(1'b0, 1'b1);
    chk("xfer_sat", 32'(xfer_count), 32'd15);
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
